rr_arbiter_8: RTL and testbench

Round-robin arbiter for eight requesters that produces the 3-bit `grant_sel` and the `grant_valid` qualifier. These feed directly into the select/enable inputs of the downstream 3-to-8 one-hot decoder, so the decoder's output becomes the per-requester grant strobe. Each grant is held until the owner signals `done`, withdraws its request, or hits a configurable hold limit. Fairness is strict rotation starting after the last granted index.

---
 rtl/rr_arbiter_8.sv | 110 +++++++++++
 tb/tb_rr_arbiter_8.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with per-grant hold limit.
// Drives grant_sel/grant_valid straight into a 3-to-8 one-hot decoder.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_sel,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [2:0]    sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          to_n;

  logic          idle_hit, rel_hit;
  logic [2:0]    idle_idx, rel_idx;
  logic [2:0]    rel_ptr;
  logic          rel, owner_req, at_lim;

  // First set bit of r scanning p, p+1, ... p+7 (mod 8).
  function automatic logic [3:0] pick(
    input logic [7:0] r,
    input logic [2:0] p
  );
    logic [2:0] idx;
    logic       hit;
    logic [2:0] res;
    hit = 1'b0;
    res = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!hit && r[idx]) begin
        hit = 1'b1;
        res = idx;
      end
    end
    return {hit, res};
  endfunction

  assign owner_req = req[grant_sel];
  assign at_lim    = (cnt == LIM);
  assign rel       = done | ~owner_req | at_lim;
  assign rel_ptr   = grant_sel + 3'd1;

  assign {idle_hit, idle_idx} = pick(req, ptr);
  assign {rel_hit, rel_idx}   = pick(req, rel_ptr);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = grant_sel;
    cnt_n   = cnt;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (idle_hit) begin
          sel_n   = idle_idx;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n = rel_ptr;
          cnt_n = '0;
          // Only a pure hold-limit release is flagged.
          to_n  = at_lim & ~done & owner_req;
          if (rel_hit) begin
            sel_n = rel_idx;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      grant_sel <= 3'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      grant_sel <= sel_n;
      timeout   <= to_n;
    end
  end

  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed + random bench for rr_arbiter_8 with a queued
// reference-model scoreboard.
module tb_rr_arbiter_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] grant_sel;
  logic       grant_valid;
  logic       timeout;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .grant_sel(grant_sel),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] s;
    logic       t;
  } exp_t;

  exp_t q[$];

  int n_assert = 0;
  int n_fail = 0;

  logic       m_valid;
  int         m_sel;
  int         m_ptr;
  int         m_cnt;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  // Reference behaviour for the edge that samples r/d.
  task automatic model(input logic [7:0] r, input logic d);
    exp_t e;
    int   w;
    logic lim;
    e.t = 1'b0;
    if (!m_valid) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_sel   = w;
        m_cnt   = 0;
      end
    end else begin
      lim = (m_cnt + 1 >= MH);
      if (d || !r[m_sel] || lim) begin
        e.t   = lim && !d && r[m_sel];
        m_ptr = (m_sel + 1) % 8;
        m_cnt = 0;
        w = first_from(r, m_ptr);
        if (w >= 0) m_sel = w;
        else m_valid = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    e.v = m_valid;
    e.s = 3'(m_sel);
    q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    model(r, d);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = q.pop_front();
      check("grant_valid", {7'd0, grant_valid}, {7'd0, e.v});
      if (e.v) check("grant_sel", {5'd0, grant_sel}, {5'd0, e.s});
      check("timeout", {7'd0, timeout}, {7'd0, e.t});
    end
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    req   = 8'h00;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", {7'd0, grant_valid}, 8'd0);
    check("rst_timeout", {7'd0, timeout}, 8'd0);
    check("rst_sel", {5'd0, grant_sel}, 8'd0);
    m_valid = 1'b0;
    m_sel   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    m_valid = 1'b0;
    m_sel   = 0;
    m_ptr   = 0;
    m_cnt   = 0;

    // Reset priority
    do_reset();
    step(8'hFF, 1'b0);
    check("first_grant_sel", {5'd0, grant_sel}, 8'd0);
    check("first_grant_valid", {7'd0, grant_valid}, 8'd1);

    // Rotation with hold-limit releases
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step(8'hFF, 1'b0);
      if (timeout) pulses++;
      if (i == 3) check("rot_to_1", {5'd0, grant_sel}, 8'd1);
    end
    check("rot_pulses", 8'(pulses), 8'd8);
    check("rot_wrap_sel", {5'd0, grant_sel}, 8'd0);

    // Early done
    do_reset();
    step(8'h24, 1'b0);
    check("early_sel2", {5'd0, grant_sel}, 8'd2);
    step(8'h24, 1'b1);
    check("early_sel5", {5'd0, grant_sel}, 8'd5);
    check("early_noto", {7'd0, timeout}, 8'd0);
    step(8'h24, 1'b1);
    check("early_back2", {5'd0, grant_sel}, 8'd2);

    // Withdrawal and wrap
    do_reset();
    step(8'h80, 1'b0);
    step(8'h01, 1'b0);
    check("wrap_sel0", {5'd0, grant_sel}, 8'd0);
    step(8'h00, 1'b0);
    check("idle_valid", {7'd0, grant_valid}, 8'd0);
    check("idle_sel_hold", {5'd0, grant_sel}, 8'd0);

    // Sole requester
    do_reset();
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      step(8'h08, 1'b0);
      if (timeout) pulses++;
    end
    check("sole_pulses", 8'(pulses), 8'd3);
    check("sole_sel", {5'd0, grant_sel}, 8'd3);

    // Done coinciding with hold limit
    do_reset();
    for (int i = 0; i < 4; i++) step(8'h03, 1'b0);
    step(8'h03, 1'b1);
    check("done_vs_lim", {7'd0, timeout}, 8'd0);

    // Async reset mid-grant
    do_reset();
    step(8'h40, 1'b0);
    step(8'h40, 1'b0);
    check("pre_rst_sel6", {5'd0, grant_sel}, 8'd6);
    do_reset();
    step(8'h41, 1'b0);
    check("post_rst_sel0", {5'd0, grant_sel}, 8'd0);

    // Random traffic against the model
    for (int i = 0; i < 200; i++)
      step(8'($urandom), ($urandom_range(0, 3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
